// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multicycle MIPS control unit.
//   - FSM state encodings (FETCH..JUMP, HALT)
//   - opcode and funct field values of the supported instructions
//   - ALUCtl, ALUSrcB and PCSrc select encodings
//   - small opcode-class helper functions used by the FSM decode
package mc_ctrl_pkg;

  localparam int ST_W = 4;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_IMMEX  = 4'd9;
  localparam logic [3:0] S_IMMWB  = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic op_is_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: connection between the FSM and the R-type ALU decoder.
//   funct   : Instr[5:0] presented by the FSM side
//   alu_ctl : ALU operation for that funct
//   illegal : funct is not one of add/sub/and/or/slt
// The decode is purely combinational; there is no handshake on this bundle.
interface mc_controller_if;
  logic [5:0] funct;
  logic [2:0] alu_ctl;
  logic       illegal;

  modport master (output funct, input alu_ctl, input illegal);
  modport slave  (input funct, output alu_ctl, output illegal);
endinterface

// File: rtl/mc_aludec.sv
// mc_aludec: combinational R-type funct -> ALUCtl decoder.
//   dec.funct   (in)  : R-type funct field
//   dec.alu_ctl (out) : 010 add, 110 sub, 000 and, 001 or, 111 slt
//   dec.illegal (out) : high for any other funct (alu_ctl then reads 010)
module mc_aludec
  import mc_ctrl_pkg::*;
(
  mc_controller_if.slave dec
);

  always_comb begin
    dec.alu_ctl = ALU_ADD;
    dec.illegal = 1'b0;
    case (dec.funct)
      F_ADD:   dec.alu_ctl = ALU_ADD;
      F_SUB:   dec.alu_ctl = ALU_SUB;
      F_AND:   dec.alu_ctl = ALU_AND;
      F_OR:    dec.alu_ctl = ALU_OR;
      F_SLT:   dec.alu_ctl = ALU_SLT;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore control FSM for the multicycle MIPS datapath.
//   CLK, Reset (async, active-low)  : clock and reset; reset forces FETCH
//   Op, Funct                      : instruction fields from the IR
//   Zero                           : ALU zero flag, used in BRANCH
//   MemReady                       : memory completion strobe
//   IorD..ExtOp, ALUCtl, ALUSrcB,
//   PCSrc                          : datapath selects/enables, decoded from state
//   Halt                           : illegal instruction trapped (sticky to reset)
//   State                          : current FSM state for board display/debug
// Build option: define MC_CTRL_WAIT_EN to add memory wait states. Memory
// accesses then complete only on a cycle with MemReady=1: FETCH, MEMRD and
// MEMWR hold their outputs and stay put while MemReady=0, and advance on the
// first cycle MemReady=1. Without the macro MemReady is ignored.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               PCEn,
  output logic               ExtOp,
  output logic [2:0]         ALUCtl,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic               Halt,
  output logic [STATE_W-1:0] State
);

  logic [ST_W-1:0] state_q, state_d;

  mc_controller_if alu_if ();
  assign alu_if.funct = Funct;

  mc_aludec u_aludec (
    .dec (alu_if.slave)
  );

`ifndef MC_CTRL_WAIT_EN
  logic unused_mem_ready;
  assign unused_mem_ready = MemReady;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign State = STATE_W'(state_q);

  always_comb begin
    state_d  = state_q;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    ALUSrcA  = 1'b0;
    RegWrite = 1'b0;
    PCEn     = 1'b0;
    ExtOp    = 1'b0;
    ALUCtl   = ALU_ADD;
    ALUSrcB  = SRCB_REG;
    PCSrc    = PCSRC_ALU;
    Halt     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB = SRCB_FOUR;
`ifdef MC_CTRL_WAIT_EN
        IRWrite = MemReady;
        PCEn    = MemReady;
        state_d = MemReady ? S_DECODE : S_FETCH;
`else
        IRWrite = 1'b1;
        PCEn    = 1'b1;
        state_d = S_DECODE;
`endif
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        ALUSrcB = SRCB_IMMSH2;
        ExtOp   = 1'b1;
        if (op_is_mem(Op))                        state_d = S_MEMADR;
        else if (Op == OP_RTYPE)                  state_d = alu_if.illegal ? S_HALT : S_EXEC;
        else if ((Op == OP_BEQ) || (Op == OP_BNE)) state_d = S_BRANCH;
        else if (op_is_imm(Op))                   state_d = S_IMMEX;
        else if (Op == OP_J)                      state_d = S_JUMP;
        else                                      state_d = S_HALT;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ExtOp   = 1'b1;
        state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD = 1'b1;
`ifdef MC_CTRL_WAIT_EN
        state_d = MemReady ? S_MEMWB : S_MEMRD;
`else
        state_d = S_MEMWB;
`endif
      end
      S_MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
`ifdef MC_CTRL_WAIT_EN
        state_d = MemReady ? S_FETCH : S_MEMWR;
`else
        state_d = S_FETCH;
`endif
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUCtl  = alu_if.alu_ctl;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUCtl  = ALU_SUB;
        PCSrc   = PCSRC_ALUOUT;
        // Only beq/bne reach here; bne takes the branch on a non-zero difference.
        PCEn    = (Op == OP_BNE) ? ~Zero : Zero;
        state_d = S_FETCH;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ExtOp   = (Op == OP_ADDI);
        case (Op)
          OP_ANDI: ALUCtl = ALU_AND;
          OP_ORI:  ALUCtl = ALU_OR;
          default: ALUCtl = ALU_ADD;
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCEn    = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        // HALT and the unused encodings 12-14 all trap until reset.
        Halt    = 1'b1;
        state_d = S_HALT;
      end
    endcase
  end

endmodule
